buffer_pop_ctrl: RTL and testbench

Read-side controller for the team's push/pop `buffer` block. It issues pop/pop_en, absorbs the buffer's one-cycle registered data_out latency and presents popped words as a valid/ready stream through a small skid FIFO. It never pops while the write side pushes, because a simultaneous push and pop is a buffer error. It detects rejected pops via the buffer's err flag and halts until software clears the fault.

---
 rtl/buffer_pop_ctrl.sv | 155 +++++++++++++++
 tb/tb_buffer_pop_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_pop_ctrl.sv
// buffer_pop_ctrl: read-side controller for the push/pop buffer.
// Issues pops when the buffer has data, absorbs the buffer's one-cycle
// registered data_out latency and presents popped words as a valid/ready
// stream through a small skid FIFO. A pop rejected by the buffer (err flag
// in the capture cycle) halts the controller until clear_err is pulsed.
// Optional feature macro: BUFFER_POP_CTRL_STATS_EN adds a 32-bit pop_count
// output counting successful captures.
// Note: rst_n is an asynchronous ACTIVE-HIGH reset despite its name.

module buffer_pop_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int SKID_DEPTH    = 2,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     clear_err,
    input  logic                     wr_push,
    input  logic                     buf_is_empty,
    input  logic                     buf_err,
    input  logic [DATA_WIDTH-1:0]    buf_data_out,
    output logic                     buf_pop_en,
    output logic                     buf_pop,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic                     halted,
    output logic [ERR_CNT_WIDTH-1:0] err_count
`ifdef BUFFER_POP_CTRL_STATS_EN
    ,
    output logic [31:0]              pop_count
`endif
);

    localparam int PTR_W = $clog2(SKID_DEPTH);
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_HALT
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    inflight;
    logic [DATA_WIDTH-1:0]   skid_mem [SKID_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        skid_count;
    logic [CNT_W:0]          occupancy;
    logic                    credit;
    logic                    pop;
    logic                    skid_wr;
    logic                    skid_rd;
    logic                    rejected;

    // A capture with err set means the buffer refused the pop from last cycle
    assign skid_wr  = inflight & ~buf_err;
    assign rejected = inflight & buf_err;
    assign skid_rd  = m_valid & m_ready;

    // Words already committed to the skid (stored + in flight) after this cycle's drain
    assign occupancy = {1'b0, skid_count}
                     + {{CNT_W{1'b0}}, inflight}
                     - {{CNT_W{1'b0}}, skid_rd};
    assign credit    = occupancy < (CNT_W + 1)'(SKID_DEPTH);

    // Pop only when it cannot collide with a push and the result has a home
    assign pop        = (state == ST_ACTIVE) & enable & ~buf_is_empty & ~wr_push & credit;
    assign buf_pop    = pop;
    assign buf_pop_en = pop;

    assign m_valid = (skid_count != '0);
    assign m_data  = skid_mem[rd_ptr];
    assign halted  = (state == ST_HALT);

    // State register and the in-flight marker for the buffer's read latency
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= ST_IDLE;
            inflight <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= pop;
        end
    end

    // Next-state logic; a rejected capture halts from any state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (rejected)
                    state_next = ST_HALT;
                else if (enable)
                    state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (rejected)
                    state_next = ST_HALT;
                else if (!enable)
                    state_next = ST_IDLE;
            end
            ST_HALT: begin
                if (!rejected && clear_err)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Skid FIFO storage and pointers; simultaneous write and read both happen
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++)
                skid_mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            skid_count <= '0;
        end else begin
            if (skid_wr) begin
                skid_mem[wr_ptr] <= buf_data_out;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (skid_rd)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({skid_wr, skid_rd})
                2'b10:   skid_count <= skid_count + CNT_W'(1);
                2'b01:   skid_count <= skid_count - CNT_W'(1);
                default: skid_count <= skid_count;
            endcase
        end
    end

    // Saturating count of pops the buffer rejected
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            err_count <= '0;
        else if (rejected && (err_count != '1))
            err_count <= err_count + ERR_CNT_WIDTH'(1);
    end

`ifdef BUFFER_POP_CTRL_STATS_EN
    // Wrapping count of words successfully captured into the skid
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            pop_count <= '0;
        else if (skid_wr)
            pop_count <= pop_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_buffer_pop_ctrl.sv
// tb_buffer_pop_ctrl: directed bench for buffer_pop_ctrl with a small
// behavioural model of the push/pop buffer (registered data_out and err).

module tb_buffer_pop_ctrl;

    localparam int DW = 8;
    localparam int SD = 2;
    localparam int EW = 8;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          clear_err;
    logic          wr_push;
    logic          buf_is_empty;
    logic          buf_err;
    logic [DW-1:0] buf_data_out;
    logic          buf_pop_en;
    logic          buf_pop;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          halted;
    logic [EW-1:0] err_count;
`ifdef BUFFER_POP_CTRL_STATS_EN
    logic [31:0]   pop_count;
`endif

    buffer_pop_ctrl #(
        .DATA_WIDTH    (DW),
        .SKID_DEPTH    (SD),
        .ERR_CNT_WIDTH (EW)
    ) dut (
`ifdef BUFFER_POP_CTRL_STATS_EN
        .pop_count    (pop_count),
`endif
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .clear_err    (clear_err),
        .wr_push      (wr_push),
        .buf_is_empty (buf_is_empty),
        .buf_err      (buf_err),
        .buf_data_out (buf_data_out),
        .buf_pop_en   (buf_pop_en),
        .buf_pop      (buf_pop),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .halted       (halted),
        .err_count    (err_count)
    );

    int   testCount = 0;
    int   failCount = 0;
    int   bufQ[$];
    int   got[$];
    bit   rejectAll = 0;
    bit   forceErr  = 0;
    int   enMismatch = 0;
    int   pushClash  = 0;
    int   overflowCount = 0;
    logic sPop;
    logic sValid;
    logic [DW-1:0] sData;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watch for a skid write into a full skid that is not drained the same cycle
    always @(negedge clk) begin
        if (!rst_n && dut.skid_wr && !dut.skid_rd && (dut.skid_count == SD))
            overflowCount++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // One clock cycle: drive inputs after negedge, sample, then update the buffer model
    task automatic applyStimulus(input logic en, input logic push,
                                 input logic ready, input logic clr);
        logic popNow;
        enable       = en;
        wr_push      = push;
        m_ready      = ready;
        clear_err    = clr;
        buf_is_empty = (bufQ.size() == 0);
        #1;
        popNow = buf_pop;
        if (buf_pop !== buf_pop_en) enMismatch++;
        if (buf_pop && wr_push)     pushClash++;
        if (m_valid && m_ready)     got.push_back(int'(m_data));
        sPop   = popNow;
        sValid = m_valid;
        sData  = m_data;
        @(posedge clk);
        @(negedge clk);
        if (popNow) begin
            if (rejectAll) begin
                buf_err = 1'b1;
            end else begin
                buf_err      = 1'b0;
                buf_data_out = DW'(bufQ.pop_front());
            end
        end else begin
            buf_err = forceErr;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n        = 1'b1;
        enable       = 1'b0;
        clear_err    = 1'b0;
        wr_push      = 1'b0;
        m_ready      = 1'b0;
        buf_err      = 1'b0;
        buf_data_out = '0;
        rejectAll    = 0;
        forceErr     = 0;
        bufQ.delete();
        got.delete();
        buf_is_empty = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic checkDelivered(input string tag, input int base, input int n);
        checkOutput({tag, "_count"}, got.size(), n);
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s_word%0d", tag, i), got[i], base + i);
    endtask

    initial begin
        int popSum;
        int timeouts;
        int waitCycles;

        rst_n = 1'b1;
        doReset();

        // Reset state
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_m_data", m_data, 0);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_err_count", err_count, 0);
        checkOutput("rst_buf_pop", buf_pop, 0);
`ifdef BUFFER_POP_CTRL_STATS_EN
        checkOutput("rst_pop_count", pop_count, 0);
`endif

        // Test 1: streaming with sink always ready
        bufQ = '{1, 2, 3, 4};
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("t1_pop_c%0d", c), sPop, (c >= 1 && c <= 4));
            checkOutput($sformatf("t1_valid_c%0d", c), sValid, (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6)
                checkOutput($sformatf("t1_data_c%0d", c), sData, c - 2);
        end
        checkDelivered("t1", 1, 4);
`ifdef BUFFER_POP_CTRL_STATS_EN
        checkOutput("t1_pop_count", pop_count, 4);
`endif

        // Test 2: back-pressure limits pops to skid depth, then drains in order
        doReset();
        bufQ = '{1, 2, 3, 4};
        popSum = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            popSum += int'(sPop);
        end
        checkOutput("t2_pops_stalled", popSum, SD);
        checkOutput("t2_valid_held", sValid, 1);
        checkOutput("t2_data_held", sData, 1);
        for (int c = 0; c < 12; c++)
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkDelivered("t2", 1, 4);

        // Test 3: pushes on alternate cycles never coincide with a pop
        doReset();
        bufQ = '{10, 11, 12, 13, 14, 15};
        pushClash = 0;
        for (int c = 0; c < 20; c++)
            applyStimulus(1'b1, logic'(c % 2), 1'b1, 1'b0);
        checkOutput("t3_push_pop_clash", pushClash, 0);
        checkDelivered("t3", 10, 6);

        // Test 4: rejected pop halts, clear_err resumes
        doReset();
        bufQ = '{7, 8};
        rejectAll = 1;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("t4_first_pop", sPop, 1);
        rejectAll = 0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t4_halted", halted, 1);
        checkOutput("t4_err_count", err_count, 1);
        checkOutput("t4_no_capture", m_valid, 0);
        popSum = 0;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
            popSum += int'(sPop);
        end
        checkOutput("t4_no_pop_in_halt", popSum, 0);
        checkOutput("t4_still_halted", halted, 1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("t4_cleared", halted, 0);
        for (int c = 0; c < 10; c++)
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkDelivered("t4", 7, 2);

        // Test 5a: buffer err with nothing in flight is ignored
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        forceErr = 1;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        forceErr = 0;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("t5_spurious_err_count", err_count, 0);
        checkOutput("t5_spurious_halted", halted, 0);

        // Test 5b: repeated rejections saturate the error counter
        bufQ = '{99};
        rejectAll = 1;
        timeouts = 0;
        for (int i = 0; i < 300; i++) begin
            waitCycles = 0;
            while (!halted && waitCycles < 8) begin
                applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
                waitCycles++;
            end
            if (!halted) timeouts++;
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        end
        rejectAll = 0;
        checkOutput("t5_halt_timeouts", timeouts, 0);
        checkOutput("t5_err_saturated", err_count, 8'hFF);

        // Test 6: asynchronous reset mid-stream
        bufQ = '{1, 2, 3, 4};
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t6_pre_valid", m_valid, 1);
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("t6_valid", m_valid, 0);
        checkOutput("t6_data", m_data, 0);
        checkOutput("t6_err_count", err_count, 0);
        checkOutput("t6_halted", halted, 0);
        checkOutput("t6_pop_in_reset", buf_pop, 0);
`ifdef BUFFER_POP_CTRL_STATS_EN
        checkOutput("t6_pop_count", pop_count, 0);
`endif
        @(negedge clk);
        rst_n   = 1'b0;
        buf_err = 1'b0;
        got.delete();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("t6_idle_after_reset", sPop, 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("t6_resume_pop", sPop, 1);

        // Global invariants accumulated over the whole run
        checkOutput("pop_en_matches_pop", enMismatch, 0);
        checkOutput("skid_no_overflow", overflowCount, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
